wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Write-back stage of the 5-stage in-order LoongArch pipeline; sits directly downstream of the memory stage and consumes its registered result, exception bundle and CSR-read request.
- Commits the register-file write and the CSR write.
- Raises the precise exception / ertn flush, exports forwarding info to decode and drives the debug trace.
- Always ready; never stalls.

Parameters:
- EX_ZIP_W, 86, width of the exception bundle {csr_we, csr_wmask[31:0], csr_wvalue[31:0], csr_num[13:0], ertn, has_int, adef, sys, brk, ine, ale}, with ale at bit 0.
- ECODE_W, 6, width of the exception code output.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ms_to_ws_valid  in  1  MEM holds a valid instruction for WB
- ws_allowin  out  1  WB can accept; constant 1
- ms_pc  in  32  instruction PC
- ms_rf_we  in  1  register write enable
- ms_rf_waddr  in  5  destination register
- ms_rf_wdata  in  32  load/ALU result; also the faulting address for ALE
- ms_csr_re  in  1  result comes from a CSR read
- ms_ex_zip  in  EX_ZIP_W  exception/CSR bundle
- csr_rvalue  in  32  CSR file read data for ws_csr_num
- csr_num  out  14  CSR read/write index
- csr_we  out  1  CSR write strobe
- csr_wmask  out  32  CSR write mask
- csr_wvalue  out  32  CSR write data
- wb_ex  out  1  exception commit; pipeline flush
- wb_ertn  out  1  ertn commit
- wb_ecode  out  ECODE_W  exception code
- wb_esubcode  out  9  exception subcode (always 0)
- wb_pc  out  32  PC of the trapping instruction
- wb_vaddr  out  32  bad virtual address
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_we  out  4  trace byte enables
- debug_wb_rf_wnum  out  5  trace destination register
- debug_wb_rf_wdata  out  32  trace write data

Behaviour:
- ws_valid register:
  - reset -> 0.
  - wb_ex or wb_ertn -> 0 next cycle.
  - otherwise <= ms_to_ws_valid.
- Payload registers load when ms_to_ws_valid & ws_allowin; every payload register resets to 0.
- Latency: one cycle from MEM handshake to commit; commit is combinational from the registers.
- ws_ex = ws_valid & |zip[5:0]. wb_ex = ws_ex. wb_ertn = ws_valid & zip[6] & ~ws_ex.
- Ecode priority, highest first:
  - has_int -> 0x00
  - adef -> 0x08
  - ine -> 0x0D
  - sys -> 0x0B
  - brk -> 0x0C
  - ale -> 0x09
- wb_esubcode = 0.
- wb_vaddr = ws_pc when adef; = ws_rf_wdata when ale; else 0.
- wb_pc = ws_pc.
- rf_we = ws_valid & ws_rf_we & ~ws_ex & ~zip[6].
- rf_waddr = ws_rf_waddr.
- rf_wdata = ws_csr_re ? csr_rvalue : ws_rf_wdata.
- csr_we = ws_valid & zip csr_we & ~ws_ex. A trapping instruction writes neither GPRs nor CSRs.
- csr_num, csr_wmask and csr_wvalue come straight from the zip.
- Debug trace:
  - debug_wb_rf_we = {4{rf_we}}.
  - debug_wb_pc, debug_wb_rf_wnum and debug_wb_rf_wdata mirror the committed values.
- Boundary conditions:
  - Reset mid-stream drops the resident instruction silently; no output pulses during reset.
  - Writes to r0 are passed through; the register file discards them.
  - A new MEM instruction arriving in the same cycle as wb_ex is dropped, because ws_valid clears.
  - Back-to-back valid instructions commit one per cycle.
- All outputs are 0 after reset. Exception: csr_num, wmask and wvalue track the zeroed zip, so they are also 0.

Optional Feature:
WB_PERF_CNT_EN:
- When defined, adds output perf_retired[63:0] and perf_trap[31:0]. Both reset to 0.
- perf_retired increments on each cycle with ws_valid & ~ws_ex.
- perf_trap increments on wb_ex.
- Both counters wrap silently.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_defs holds:
  - ECODE_INT/ADEF/ALE/SYS/BRK/INE localparams.
  - The EX_ZIP bit-position constants.
  - The CSR number width.
- One sub-module, wb_ecode_enc, handles the priority encoding of zip[5:0] into ecode and the vaddr-select signal.

Test Plan:
- ALU writeback: valid, pc=0x1C000000, rf_we=1, waddr=5, wdata=0x1234, zip=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, debug_wb_rf_we=0xF, wb_ex=0.
- CSR read: ms_csr_re=1, csr_num=0x0005, csr_rvalue=0xABCD0000 -> rf_wdata=0xABCD0000, csr_num=5.
- Trap precedence: zip with has_int and ale both set -> wb_ex=1, ecode=0x00, rf_we=0, csr_we=0; ws_valid=0 the following cycle.
- ALE: ale only, wdata=0x1C000003 -> wb_ecode=0x09, wb_vaddr=0x1C000003, no register write.
- ertn: zip[6]=1, no other exception bits -> wb_ertn=1, wb_ex=0, rf_we=0; an instruction arriving in the same cycle is dropped.
- Reset: assert reset with a valid instruction resident -> all outputs 0 on the next edge; perf counters (if WB_PERF_CNT_EN is defined) are 0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared LoongArch pipeline definitions: exception codes, EX_ZIP bundle layout
// and CSR index width, imported by the write-back stage and its encoder.
package cpu_defs;

  localparam int EX_ZIP_W  = 86;
  localparam int ECODE_W   = 6;
  localparam int CSR_NUM_W = 14;

  // EX_ZIP layout: {csr_we, csr_wmask, csr_wvalue, csr_num, ertn, has_int, adef, sys, brk, ine, ale}
  localparam int ZIP_ALE            = 0;
  localparam int ZIP_INE            = 1;
  localparam int ZIP_BRK            = 2;
  localparam int ZIP_SYS            = 3;
  localparam int ZIP_ADEF           = 4;
  localparam int ZIP_HAS_INT        = 5;
  localparam int ZIP_ERTN           = 6;
  localparam int ZIP_CSR_NUM_LSB    = 7;
  localparam int ZIP_CSR_NUM_MSB    = 20;
  localparam int ZIP_CSR_WVALUE_LSB = 21;
  localparam int ZIP_CSR_WVALUE_MSB = 52;
  localparam int ZIP_CSR_WMASK_LSB  = 53;
  localparam int ZIP_CSR_WMASK_MSB  = 84;
  localparam int ZIP_CSR_WE         = 85;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  typedef enum logic [1:0] {
    VADDR_NONE = 2'd0,
    VADDR_PC   = 2'd1,
    VADDR_DATA = 2'd2
  } vaddr_sel_e;

  function automatic logic zip_has_ex(input logic [5:0] ex_bits);
    return |ex_bits;
  endfunction

endpackage

// File: rtl/wb_stage_ecode_enc.sv
// Priority encoder turning the six exception flags of EX_ZIP into an ecode
// and choosing which value reports the bad virtual address.
module wb_ecode_enc
  import cpu_defs::*;
#(
  parameter int ECODE_W = 6
) (
  input  logic [5:0]         ex_bits,
  output logic [ECODE_W-1:0] ecode,
  output vaddr_sel_e         vaddr_sel
);

  always_comb begin
    ecode = '0;
    if (ex_bits[ZIP_HAS_INT])   ecode = ECODE_W'(ECODE_INT);
    else if (ex_bits[ZIP_ADEF]) ecode = ECODE_W'(ECODE_ADEF);
    else if (ex_bits[ZIP_INE])  ecode = ECODE_W'(ECODE_INE);
    else if (ex_bits[ZIP_SYS])  ecode = ECODE_W'(ECODE_SYS);
    else if (ex_bits[ZIP_BRK])  ecode = ECODE_W'(ECODE_BRK);
    else if (ex_bits[ZIP_ALE])  ecode = ECODE_W'(ECODE_ALE);
  end

  // A fetch fault reports the PC; a misaligned access reports the data address.
  always_comb begin
    vaddr_sel = VADDR_NONE;
    if (ex_bits[ZIP_ADEF])     vaddr_sel = VADDR_PC;
    else if (ex_bits[ZIP_ALE]) vaddr_sel = VADDR_DATA;
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits GPR/CSR writes, raises exception/ertn flushes and
// drives the debug trace. WB_PERF_CNT_EN adds retired/trap counters.
module wb_stage
  import cpu_defs::*;
#(
  parameter int EX_ZIP_W = 86,
  parameter int ECODE_W  = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ms_to_ws_valid,
  output logic                 ws_allowin,
  input  logic [31:0]          ms_pc,
  input  logic                 ms_rf_we,
  input  logic [4:0]           ms_rf_waddr,
  input  logic [31:0]          ms_rf_wdata,
  input  logic                 ms_csr_re,
  input  logic [EX_ZIP_W-1:0]  ms_ex_zip,
  input  logic [31:0]          csr_rvalue,
  output logic [13:0]          csr_num,
  output logic                 csr_we,
  output logic [31:0]          csr_wmask,
  output logic [31:0]          csr_wvalue,
  output logic                 wb_ex,
  output logic                 wb_ertn,
  output logic [ECODE_W-1:0]   wb_ecode,
  output logic [8:0]           wb_esubcode,
  output logic [31:0]          wb_pc,
  output logic [31:0]          wb_vaddr,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
`ifdef WB_PERF_CNT_EN
  output logic [63:0]          perf_retired,
  output logic [31:0]          perf_trap,
`endif
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
);

  // Handshake: ms_to_ws_valid transfers an instruction on a clock edge when
  // ws_allowin is high; WB never back-pressures, so every offer is taken.
  logic                ws_valid_q, ws_valid_d;
  logic [31:0]         ws_pc_q, ws_pc_d;
  logic                ws_rf_we_q, ws_rf_we_d;
  logic [4:0]          ws_rf_waddr_q, ws_rf_waddr_d;
  logic [31:0]         ws_rf_wdata_q, ws_rf_wdata_d;
  logic                ws_csr_re_q, ws_csr_re_d;
  logic [EX_ZIP_W-1:0] ws_zip_q, ws_zip_d;

  logic               ws_ex;
  logic               zip_ertn;
  logic               accept;
  logic [ECODE_W-1:0] enc_ecode;
  vaddr_sel_e         enc_vaddr_sel;

  assign ws_allowin = 1'b1;
  assign accept     = ms_to_ws_valid & ws_allowin;

  always_comb begin
    ws_valid_d    = ms_to_ws_valid;
    ws_pc_d       = ws_pc_q;
    ws_rf_we_d    = ws_rf_we_q;
    ws_rf_waddr_d = ws_rf_waddr_q;
    ws_rf_wdata_d = ws_rf_wdata_q;
    ws_csr_re_d   = ws_csr_re_q;
    ws_zip_d      = ws_zip_q;
    // A flush kills whatever MEM offers in the same cycle.
    if (wb_ex || wb_ertn) ws_valid_d = 1'b0;
    if (accept) begin
      ws_pc_d       = ms_pc;
      ws_rf_we_d    = ms_rf_we;
      ws_rf_waddr_d = ms_rf_waddr;
      ws_rf_wdata_d = ms_rf_wdata;
      ws_csr_re_d   = ms_csr_re;
      ws_zip_d      = ms_ex_zip;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q    <= 1'b0;
      ws_pc_q       <= '0;
      ws_rf_we_q    <= 1'b0;
      ws_rf_waddr_q <= '0;
      ws_rf_wdata_q <= '0;
      ws_csr_re_q   <= 1'b0;
      ws_zip_q      <= '0;
    end else begin
      ws_valid_q    <= ws_valid_d;
      ws_pc_q       <= ws_pc_d;
      ws_rf_we_q    <= ws_rf_we_d;
      ws_rf_waddr_q <= ws_rf_waddr_d;
      ws_rf_wdata_q <= ws_rf_wdata_d;
      ws_csr_re_q   <= ws_csr_re_d;
      ws_zip_q      <= ws_zip_d;
    end
  end

  wb_ecode_enc #(
    .ECODE_W (ECODE_W)
  ) u_ecode_enc (
    .ex_bits   (ws_zip_q[ZIP_HAS_INT:ZIP_ALE]),
    .ecode     (enc_ecode),
    .vaddr_sel (enc_vaddr_sel)
  );

  assign zip_ertn = ws_zip_q[ZIP_ERTN];
  assign ws_ex    = ws_valid_q & zip_has_ex(ws_zip_q[ZIP_HAS_INT:ZIP_ALE]);

  always_comb begin
    wb_ex       = ws_ex;
    wb_ertn     = ws_valid_q & zip_ertn & ~ws_ex;
    wb_ecode    = enc_ecode;
    wb_esubcode = '0;
    wb_pc       = ws_pc_q;
    wb_vaddr    = '0;
    case (enc_vaddr_sel)
      VADDR_PC:   wb_vaddr = ws_pc_q;
      VADDR_DATA: wb_vaddr = ws_rf_wdata_q;
      default:    wb_vaddr = '0;
    endcase
  end

  // Trapping or returning instructions leave architectural GPR state untouched.
  always_comb begin
    rf_we      = ws_valid_q & ws_rf_we_q & ~ws_ex & ~zip_ertn;
    rf_waddr   = ws_rf_waddr_q;
    rf_wdata   = ws_csr_re_q ? csr_rvalue : ws_rf_wdata_q;
    csr_we     = ws_valid_q & ws_zip_q[ZIP_CSR_WE] & ~ws_ex;
    csr_num    = ws_zip_q[ZIP_CSR_NUM_MSB:ZIP_CSR_NUM_LSB];
    csr_wmask  = ws_zip_q[ZIP_CSR_WMASK_MSB:ZIP_CSR_WMASK_LSB];
    csr_wvalue = ws_zip_q[ZIP_CSR_WVALUE_MSB:ZIP_CSR_WVALUE_LSB];
  end

  always_comb begin
    debug_wb_pc       = ws_pc_q;
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end

`ifdef WB_PERF_CNT_EN
  logic [63:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_trap_q, perf_trap_d;

  always_comb begin
    perf_retired_d = perf_retired_q;
    perf_trap_d    = perf_trap_q;
    if (ws_valid_q && !ws_ex) perf_retired_d = perf_retired_q + 64'd1;
    if (wb_ex)                perf_trap_d    = perf_trap_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retired_q <= '0;
      perf_trap_q    <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_trap_q    <= perf_trap_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_trap    = perf_trap_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: one task per scenario, each with
// hand-computed expectations.
module tb_wb_stage;

  localparam int ZW = 86;

  logic          clk;
  logic          reset;
  logic          ms_to_ws_valid;
  logic          ws_allowin;
  logic [31:0]   ms_pc;
  logic          ms_rf_we;
  logic [4:0]    ms_rf_waddr;
  logic [31:0]   ms_rf_wdata;
  logic          ms_csr_re;
  logic [ZW-1:0] ms_ex_zip;
  logic [31:0]   csr_rvalue;
  logic [13:0]   csr_num;
  logic          csr_we;
  logic [31:0]   csr_wmask;
  logic [31:0]   csr_wvalue;
  logic          wb_ex;
  logic          wb_ertn;
  logic [5:0]    wb_ecode;
  logic [8:0]    wb_esubcode;
  logic [31:0]   wb_pc;
  logic [31:0]   wb_vaddr;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
`ifdef WB_PERF_CNT_EN
  logic [63:0]   perf_retired;
  logic [31:0]   perf_trap;
`endif
  logic [31:0]   debug_wb_pc;
  logic [3:0]    debug_wb_rf_we;
  logic [4:0]    debug_wb_rf_wnum;
  logic [31:0]   debug_wb_rf_wdata;

  int checks;
  int errors;

  wb_stage u_dut (
    .clk               (clk),
    .reset             (reset),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ws_allowin        (ws_allowin),
    .ms_pc             (ms_pc),
    .ms_rf_we          (ms_rf_we),
    .ms_rf_waddr       (ms_rf_waddr),
    .ms_rf_wdata       (ms_rf_wdata),
    .ms_csr_re         (ms_csr_re),
    .ms_ex_zip         (ms_ex_zip),
    .csr_rvalue        (csr_rvalue),
    .csr_num           (csr_num),
    .csr_we            (csr_we),
    .csr_wmask         (csr_wmask),
    .csr_wvalue        (csr_wvalue),
    .wb_ex             (wb_ex),
    .wb_ertn           (wb_ertn),
    .wb_ecode          (wb_ecode),
    .wb_esubcode       (wb_esubcode),
    .wb_pc             (wb_pc),
    .wb_vaddr          (wb_vaddr),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
`ifdef WB_PERF_CNT_EN
    .perf_retired      (perf_retired),
    .perf_trap         (perf_trap),
`endif
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  function automatic logic [ZW-1:0] mk_zip(input logic c_we, input logic [31:0] mask,
                                           input logic [31:0] value, input logic [13:0] num,
                                           input logic ertn, input logic [5:0] ex);
    return {c_we, mask, value, num, ertn, ex};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic cre, input logic [ZW-1:0] zip);
    ms_to_ws_valid = v;
    ms_pc          = pc;
    ms_rf_we       = we;
    ms_rf_waddr    = wa;
    ms_rf_wdata    = wd;
    ms_csr_re      = cre;
    ms_ex_zip      = zip;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle();
    csr_rvalue = 32'h0;
    repeat (3) step();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, wb_ex, wb_ertn, wb_ecode, wb_esubcode, wb_pc, wb_vaddr,
         csr_we, csr_num, csr_wmask, csr_wvalue, debug_wb_pc, debug_wb_rf_we,
         debug_wb_rf_wnum, debug_wb_rf_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rf_we=%b rf_waddr=%0d rf_wdata=%h wb_ex=%b wb_pc=%h csr_num=%h expected all 0",
               rf_we, rf_waddr, rf_wdata, wb_ex, wb_pc, csr_num);
    end
    checks++;
    if (ws_allowin !== 1'b1) begin
      errors++;
      $display("FAIL allowin: got %b expected 1", ws_allowin);
    end
`ifdef WB_PERF_CNT_EN
    checks++;
    if (perf_retired !== 64'd0 || perf_trap !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: retired=%0d trap=%0d expected 0 0", perf_retired, perf_trap);
    end
`endif
    reset = 1'b0;
    step();
  endtask

  task automatic test_alu_wb();
    drive(1'b1, 32'h1C00_0000, 1'b1, 5'd5, 32'h0000_1234, 1'b0, '0);
    step();
    idle();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234 || wb_ex !== 1'b0) begin
      errors++;
      $display("FAIL alu_wb: we=%b waddr=%0d wdata=%h ex=%b expected 1 5 1234 0",
               rf_we, rf_waddr, rf_wdata, wb_ex);
    end
    checks++;
    if (debug_wb_rf_we !== 4'hF || debug_wb_pc !== 32'h1C00_0000 ||
        debug_wb_rf_wnum !== 5'd5 || debug_wb_rf_wdata !== 32'h1234) begin
      errors++;
      $display("FAIL alu_trace: we=%h pc=%h wnum=%0d wdata=%h expected f 1c000000 5 1234",
               debug_wb_rf_we, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
    step();
    checks++;
    if (rf_we !== 1'b0 || debug_wb_rf_we !== 4'h0) begin
      errors++;
      $display("FAIL alu_idle: rf_we=%b trace_we=%h expected 0 0", rf_we, debug_wb_rf_we);
    end
`ifdef WB_PERF_CNT_EN
    checks++;
    if (perf_retired !== 64'd1) begin
      errors++;
      $display("FAIL perf_retired: got %0d expected 1", perf_retired);
    end
`endif
  endtask

  task automatic test_csr();
    csr_rvalue = 32'hABCD_0000;
    drive(1'b1, 32'h1C00_0004, 1'b1, 5'd7, 32'h0000_5555, 1'b1,
          mk_zip(1'b1, 32'h0000_FFFF, 32'h0000_0055, 14'h0005, 1'b0, 6'b0));
    step();
    idle();
    checks++;
    if (rf_wdata !== 32'hABCD_0000 || csr_num !== 14'h0005 || rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
      errors++;
      $display("FAIL csr_read: wdata=%h csr_num=%h we=%b waddr=%0d expected abcd0000 0005 1 7",
               rf_wdata, csr_num, rf_we, rf_waddr);
    end
    checks++;
    if (csr_we !== 1'b1 || csr_wmask !== 32'h0000_FFFF || csr_wvalue !== 32'h0000_0055) begin
      errors++;
      $display("FAIL csr_write: we=%b mask=%h value=%h expected 1 0000ffff 00000055",
               csr_we, csr_wmask, csr_wvalue);
    end
    step();
  endtask

  task automatic test_trap_precedence();
    drive(1'b1, 32'h1C00_0010, 1'b1, 5'd3, 32'h0000_0007, 1'b0,
          mk_zip(1'b1, 32'hFFFF_FFFF, 32'h1, 14'h0006, 1'b0, 6'b100001));
    step();
    // Another instruction arrives during the trap cycle and must be dropped.
    drive(1'b1, 32'h1C00_0014, 1'b1, 5'd4, 32'h0000_0099, 1'b0, '0);
    checks++;
    if (wb_ex !== 1'b1 || wb_ecode !== 6'h00 || rf_we !== 1'b0 || csr_we !== 1'b0) begin
      errors++;
      $display("FAIL trap_int_ale: ex=%b ecode=%h rf_we=%b csr_we=%b expected 1 00 0 0",
               wb_ex, wb_ecode, rf_we, csr_we);
    end
    checks++;
    if (wb_pc !== 32'h1C00_0010 || wb_esubcode !== 9'd0) begin
      errors++;
      $display("FAIL trap_pc: pc=%h esub=%h expected 1c000010 000", wb_pc, wb_esubcode);
    end
    step();
    idle();
    checks++;
    if (rf_we !== 1'b0 || wb_ex !== 1'b0 || debug_wb_rf_we !== 4'h0) begin
      errors++;
      $display("FAIL trap_drop: rf_we=%b ex=%b trace_we=%h expected 0 0 0", rf_we, wb_ex, debug_wb_rf_we);
    end
    step();
  endtask

  task automatic test_ale();
    drive(1'b1, 32'h1C00_0020, 1'b1, 5'd9, 32'h1C00_0003, 1'b0,
          mk_zip(1'b0, 32'h0, 32'h0, 14'h0, 1'b0, 6'b000001));
    step();
    idle();
    checks++;
    if (wb_ex !== 1'b1 || wb_ecode !== 6'h09 || wb_vaddr !== 32'h1C00_0003 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL ale: ex=%b ecode=%h vaddr=%h rf_we=%b expected 1 09 1c000003 0",
               wb_ex, wb_ecode, wb_vaddr, rf_we);
    end
    step();
  endtask

  task automatic test_ecode_priority();
    logic [5:0] ex_tab [5];
    logic [5:0] ec_tab [5];
    ex_tab[0] = 6'b010010; ec_tab[0] = 6'h08;
    ex_tab[1] = 6'b001010; ec_tab[1] = 6'h0D;
    ex_tab[2] = 6'b001100; ec_tab[2] = 6'h0B;
    ex_tab[3] = 6'b000101; ec_tab[3] = 6'h0C;
    ex_tab[4] = 6'b111111; ec_tab[4] = 6'h00;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1C00_0100 + 32'(i * 4), 1'b1, 5'd2, 32'hDEAD_0000 + 32'(i), 1'b0,
            mk_zip(1'b0, 32'h0, 32'h0, 14'h0, 1'b0, ex_tab[i]));
      step();
      idle();
      checks++;
      if (wb_ex !== 1'b1 || wb_ecode !== ec_tab[i] || rf_we !== 1'b0) begin
        errors++;
        $display("FAIL ecode_prio[%0d]: ex=%b ecode=%h rf_we=%b expected 1 %h 0",
                 i, wb_ex, wb_ecode, rf_we, ec_tab[i]);
      end
      step();
    end
    // ADEF reports the fetch PC as the bad address.
    drive(1'b1, 32'h1C00_0201, 1'b0, 5'd0, 32'h1111_2222, 1'b0,
          mk_zip(1'b0, 32'h0, 32'h0, 14'h0, 1'b0, 6'b010000));
    step();
    idle();
    checks++;
    if (wb_vaddr !== 32'h1C00_0201 || wb_ecode !== 6'h08) begin
      errors++;
      $display("FAIL adef_vaddr: vaddr=%h ecode=%h expected 1c000201 08", wb_vaddr, wb_ecode);
    end
    step();
  endtask

  task automatic test_ertn();
    drive(1'b1, 32'h1C00_0300, 1'b1, 5'd6, 32'h0000_0042, 1'b0,
          mk_zip(1'b0, 32'h0, 32'h0, 14'h0, 1'b1, 6'b0));
    step();
    drive(1'b1, 32'h1C00_0304, 1'b1, 5'd8, 32'h0000_0077, 1'b0, '0);
    checks++;
    if (wb_ertn !== 1'b1 || wb_ex !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL ertn: ertn=%b ex=%b rf_we=%b expected 1 0 0", wb_ertn, wb_ex, rf_we);
    end
    step();
    idle();
    checks++;
    if (rf_we !== 1'b0 || wb_ertn !== 1'b0) begin
      errors++;
      $display("FAIL ertn_drop: rf_we=%b ertn=%b expected 0 0", rf_we, wb_ertn);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  wa_tab [4];
    logic [31:0] wd_tab [4];
    wa_tab[0] = 5'd0;  wd_tab[0] = 32'hAAAA_0000;
    wa_tab[1] = 5'd1;  wd_tab[1] = 32'h0000_0001;
    wa_tab[2] = 5'd31; wd_tab[2] = 32'hFFFF_FFFF;
    wa_tab[3] = 5'd10; wd_tab[3] = 32'h1357_9BDF;
    drive(1'b1, 32'h1C00_0400, 1'b1, wa_tab[0], wd_tab[0], 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) drive(1'b1, 32'h1C00_0404 + 32'(i * 4), 1'b1, wa_tab[i+1], wd_tab[i+1], 1'b0, '0);
      else       idle();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== wa_tab[i] || rf_wdata !== wd_tab[i] ||
          debug_wb_pc !== 32'h1C00_0400 + 32'(i * 4)) begin
        errors++;
        $display("FAIL b2b[%0d]: we=%b waddr=%0d wdata=%h pc=%h expected 1 %0d %h %h", i, rf_we,
                 rf_waddr, rf_wdata, debug_wb_pc, wa_tab[i], wd_tab[i], 32'h1C00_0400 + 32'(i * 4));
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h1C00_0500, 1'b1, 5'd12, 32'h0BAD_F00D, 1'b0,
          mk_zip(1'b1, 32'hFFFF_FFFF, 32'h0000_00AA, 14'h0011, 1'b0, 6'b0));
    step();
    checks++;
    if (rf_we !== 1'b1 || csr_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_resident: rf_we=%b csr_we=%b expected 1 1", rf_we, csr_we);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, wb_ex, wb_ertn, wb_pc, csr_we, csr_num, csr_wmask, csr_wvalue,
         debug_wb_pc, debug_wb_rf_we} !== '0) begin
      errors++;
      $display("FAIL mid_reset: rf_we=%b wdata=%h pc=%h csr_we=%b csr_num=%h expected all 0",
               rf_we, rf_wdata, wb_pc, csr_we, csr_num);
    end
`ifdef WB_PERF_CNT_EN
    checks++;
    if (perf_retired !== 64'd0 || perf_trap !== 32'd0) begin
      errors++;
      $display("FAIL perf_mid_reset: retired=%0d trap=%0d expected 0 0", perf_retired, perf_trap);
    end
`endif
    idle();
    reset = 1'b0;
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu_wb();
    test_csr();
    test_trap_precedence();
    test_ale();
    test_ecode_priority();
    test_ertn();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
